mult_share_arbiter: RTL



---
 rtl/mult_share_arbiter_if.sv | 36 +++
 rtl/mult_share_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: requester, shared-multiplier and response signals of
// mult_share_arbiter. The slave modport is the arbiter's view; the master modport is
// the view of the environment (requesters, multiplier and response consumer).
interface mult_share_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    // Requester side: one valid/ready pair per requester, operands packed 16 bits each
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;

    // Shared combinational multiplier
    logic [15:0]          mul_a;
    logic [15:0]          mul_b;
    logic [32:0]          mul_p;

    // Response channel
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [32:0]          rsp_prod;
    logic [IDW-1:0]       rsp_id;

    logic                 busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_prod, rsp_id, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_prod, rsp_id, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin arbiter/sequencer sharing one combinational 16x16
// unsigned multiplier among NREQ requesters. The granted operands are registered onto
// the multiplier, the product is captured after MUL_LAT settle cycles and returned with
// the requester index over a valid/ready response channel.
// Optional feature macro: MULT_SHARE_ZERO_SKIP_EN -- a zero operand returns a zero
// product one cycle after acceptance instead of waiting MUL_LAT cycles.
module mult_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned IDW     = 2
) (
    input logic                 clk,
    input logic                 rst,
    mult_share_arbiter_if.slave bus
);

`ifdef MULT_SHARE_ZERO_SKIP_EN
    localparam bit ZeroSkipEn = 1'b1;
`else
    localparam bit ZeroSkipEn = 1'b0;
`endif

    localparam logic [3:0]     LatInit  = 4'(MUL_LAT);
    // Pointer starts at the last requester so requester 0 has first priority
    localparam logic [IDW-1:0] LastInit = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            zero_q, zero_d;
    logic [15:0]     mul_a_q, mul_a_d;
    logic [15:0]     mul_b_q, mul_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [32:0]     rsp_prod_q, rsp_prod_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;

    logic            any_req;
    logic [IDW-1:0]  win_idx;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic [15:0]     sel_a;
    logic [15:0]     sel_b;
    logic            sel_zero;

    // Round-robin search: first valid requester upward from last+1, wrapping at NREQ
    always_comb begin
        logic [IDW:0] idx;
        idx     = '0;
        any_req = 1'b0;
        win_idx = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = {1'b0, last_q} + (IDW+1)'(k + 1);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!any_req && bus.req_valid[idx[IDW-1:0]]) begin
                any_req = 1'b1;
                win_idx = idx[IDW-1:0];
            end
        end
    end

    // One-hot grant to the winner, only while idle and not held in reset
    always_comb begin
        grant = '0;
        if (state_q == StIdle && any_req && !rst) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign accept   = |(grant & bus.req_valid);
    assign sel_a    = bus.req_a[16*win_idx +: 16];
    assign sel_b    = bus.req_b[16*win_idx +: 16];
    assign sel_zero = (sel_a == 16'd0) || (sel_b == 16'd0);

    // Next-state and datapath updates for the IDLE -> WAIT -> RESP sequence
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_prod_d  = rsp_prod_q;
        rsp_id_d    = rsp_id_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    mul_a_d = sel_a;
                    mul_b_d = sel_b;
                    id_d    = win_idx;
                    last_d  = win_idx;
                    state_d = StWait;
                    // A zero operand needs no settling: one WAIT cycle, forced zero product
                    if (ZeroSkipEn && sel_zero) begin
                        cnt_d  = 4'd1;
                        zero_d = 1'b1;
                    end else begin
                        cnt_d  = LatInit;
                        zero_d = 1'b0;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_prod_d  = zero_q ? 33'd0 : bus.mul_p;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= LastInit;
            id_q        <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_prod_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_prod_q  <= rsp_prod_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_prod  = rsp_prod_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state_q != StIdle);

endmodule
